// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared signed MAC walks TAPS coefficients per accepted sample.
// Optional macro FIR_MAC_SATURATE_EN clamps the result to N bits and adds a sat_flag output.
module fir_mac_sequencer #(
  parameter int N    = 16,
  parameter int TAPS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic signed [N-1:0] dataIn1,
  input  logic                rIn1,
  output logic                ready,
  output logic        [N-1:0] dataOut1,
  output logic                r_out,
`ifdef FIR_MAC_SATURATE_EN
  output logic                sat_flag,
`endif
  input  logic                cfg_we,
  input  logic        [3:0]   cfg_addr,
  input  logic signed [N-1:0] cfg_data
);

  localparam int ACCW = 2 * N + 4;
  localparam int KW   = (TAPS > 1) ? $clog2(TAPS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic signed [N-1:0]    dly_q  [TAPS];
  logic signed [N-1:0]    dly_d  [TAPS];
  logic signed [N-1:0]    coef_q [TAPS];
  logic signed [N-1:0]    coef_d [TAPS];
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic        [KW-1:0]   k_q, k_d;
  logic        [N-1:0]    dout_q, dout_d;
  logic                   rout_q, rout_d;
  logic signed [2*N-1:0]  prod_s;
`ifdef FIR_MAC_SATURATE_EN
  logic                   sat_q, sat_d;
  logic        [N:0]      clamp_s;

  // Returns {clamped, value}: in range when every bit above N-2 matches the sign.
  function automatic logic [N:0] sat_clamp(input logic signed [ACCW-1:0] a);
    logic [ACCW-N:0] hi;
    hi = a[ACCW-1:N-1];
    if ((&hi) || !(|hi)) sat_clamp = {1'b0, a[N-1:0]};
    else if (a[ACCW-1])  sat_clamp = {1'b1, 1'b1, {(N-1){1'b0}}};
    else                 sat_clamp = {1'b1, 1'b0, {(N-1){1'b1}}};
  endfunction

  assign clamp_s  = sat_clamp(acc_q);
  assign sat_flag = sat_q;
`endif

  assign prod_s   = (2*N)'(coef_q[k_q]) * (2*N)'(dly_q[k_q]);
  assign ready    = (state_q == IDLE);
  assign dataOut1 = dout_q;
  assign r_out    = rout_q;

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    coef_d  = coef_q;
    acc_d   = acc_q;
    k_d     = k_q;
    dout_d  = dout_q;
    rout_d  = 1'b0;
`ifdef FIR_MAC_SATURATE_EN
    sat_d   = 1'b0;
`endif
    for (int i = 0; i < TAPS; i++) begin
      coef_d[i] = (cfg_we && (state_q == IDLE) && (cfg_addr == 4'(i))) ? cfg_data : coef_q[i];
    end
    case (state_q)
      IDLE: begin
        if (rIn1) begin
          dly_d[0] = dataIn1;
          for (int i = 1; i < TAPS; i++) dly_d[i] = dly_q[i-1];
          acc_d   = '0;
          k_d     = '0;
          state_d = MAC;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        acc_d = acc_q + ACCW'(prod_s);
        if (k_q == KW'(TAPS - 1)) begin
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = MAC;
        end
      end
      DONE: begin
`ifdef FIR_MAC_SATURATE_EN
        dout_d = clamp_s[N-1:0];
        sat_d  = clamp_s[N];
`else
        dout_d = acc_q[N-1:0];
`endif
        rout_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset wins over enable; enable low freezes every register including the output pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      k_q     <= '0;
      dout_q  <= '0;
      rout_q  <= 1'b0;
`ifdef FIR_MAC_SATURATE_EN
      sat_q   <= 1'b0;
`endif
      for (int i = 0; i < TAPS; i++) begin
        dly_q[i]  <= '0;
        coef_q[i] <= N'(TAPS - i);
      end
    end else if (enable) begin
      state_q <= state_d;
      dly_q   <= dly_d;
      coef_q  <= coef_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      dout_q  <= dout_d;
      rout_q  <= rout_d;
`ifdef FIR_MAC_SATURATE_EN
      sat_q   <= sat_d;
`endif
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: directed steps plus random traffic against a
// latency/arithmetic reference model. Honours FIR_MAC_SATURATE_EN for the sat_flag port.
module tb_fir_mac_sequencer;
  localparam int N    = 16;
  localparam int TAPS = 4;

  logic          clk = 1'b0;
  logic          rst, enable, rIn1, ready, r_out, cfg_we;
  logic [N-1:0]  dataIn1, dataOut1, cfg_data;
  logic [3:0]    cfg_addr;
`ifdef FIR_MAC_SATURATE_EN
  logic          sat_flag;
`endif

  always #5 clk = ~clk;

  fir_mac_sequencer #(.N(N), .TAPS(TAPS)) dut (
    .clk(clk), .rst(rst), .enable(enable), .dataIn1(dataIn1), .rIn1(rIn1),
    .ready(ready), .dataOut1(dataOut1), .r_out(r_out),
`ifdef FIR_MAC_SATURATE_EN
    .sat_flag(sat_flag),
`endif
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
  );

  int            n_cmp = 0;
  int            n_bad = 0;
  int            m_coef [TAPS];
  int            m_dly  [TAPS];
  int            m_left;
  logic [15:0]   m_dout, m_pend;
  logic          m_rout, m_sat, m_pend_sat;
  logic [15:0]   res_q [$];

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin
      m_coef[i] = TAPS - i;
      m_dly[i]  = 0;
    end
    m_left = 0; m_dout = 16'h0000; m_rout = 1'b0; m_sat = 1'b0;
  endtask

  // Filter output from the definition: sum of coef*sample, then wrap or clamp to 16 bits.
  task automatic model_compute();
    longint s;
    s = 0;
    for (int i = 0; i < TAPS; i++) s += longint'(m_coef[i]) * longint'(m_dly[i]);
`ifdef FIR_MAC_SATURATE_EN
    if (s > 32767)       begin m_pend = 16'h7FFF; m_pend_sat = 1'b1; end
    else if (s < -32768) begin m_pend = 16'h8000; m_pend_sat = 1'b1; end
    else                 begin m_pend = s[15:0];  m_pend_sat = 1'b0; end
`else
    m_pend = s[15:0]; m_pend_sat = 1'b0;
`endif
  endtask

  task automatic model_edge();
    bit rdy;
    if (!rst) model_reset();
    else if (enable) begin
      rdy = (m_left == 0);
      m_rout = 1'b0; m_sat = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin m_rout = 1'b1; m_dout = m_pend; m_sat = m_pend_sat; end
      end
      if (rdy && cfg_we && (cfg_addr < TAPS)) m_coef[cfg_addr] = int'($signed(cfg_data));
      if (rdy && rIn1) begin
        for (int i = TAPS - 1; i > 0; i--) m_dly[i] = m_dly[i-1];
        m_dly[0] = int'($signed(dataIn1));
        model_compute();
        m_left = TAPS + 1;
      end
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input logic en, input logic rn, input logic rin, input logic [15:0] din,
                     input logic we, input logic [3:0] addr, input logic [15:0] cd);
    enable = en; rst = rn; rIn1 = rin; dataIn1 = din; cfg_we = we; cfg_addr = addr; cfg_data = cd;
    @(posedge clk);
    model_edge();
    #1;
    chk_bit("ready", ready, (m_left == 0));
    chk_bit("r_out", r_out, m_rout);
    chk16("dataOut1", dataOut1, m_dout);
`ifdef FIR_MAC_SATURATE_EN
    chk_bit("sat_flag", sat_flag, m_sat);
`endif
    if (r_out === 1'b1 && en && rn) res_q.push_back(dataOut1);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 4'h0, 16'h0000);
  endtask

  task automatic feed(input logic [15:0] d);
    int n;
    cyc(1'b1, 1'b1, 1'b1, d, 1'b0, 4'h0, 16'h0000);
    n = 0;
    while (ready !== 1'b1 && n < 20) begin idle(); n++; end
    if (ready !== 1'b1) chk_bit("feed_timeout", ready, 1'b1);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 16'h0000);
  endtask

  task automatic wcoef(input logic [3:0] a, input logic [15:0] v);
    cyc(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, a, v);
  endtask

  initial begin
    logic [15:0] imp_exp [5];
    int lat;
    imp_exp[0] = 16'd4; imp_exp[1] = 16'd3; imp_exp[2] = 16'd2; imp_exp[3] = 16'd1; imp_exp[4] = 16'd0;
    rst = 1'b0; enable = 1'b0; rIn1 = 1'b0; dataIn1 = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    model_reset();

    // Reset state, applied with enable low.
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    do_reset();
    chk_bit("rst_ready", ready, 1'b1);
    chk_bit("rst_rout", r_out, 1'b0);
    chk16("rst_dout", dataOut1, 16'h0000);

    // Impulse response.
    res_q.delete();
    feed(16'd1); feed(16'd0); feed(16'd0); feed(16'd0); feed(16'd0);
    chk_int("imp_count", res_q.size(), 5);
    for (int i = 0; i < 5; i++)
      chk16("imp_val", (i < res_q.size()) ? res_q[i] : 16'hDEAD, imp_exp[i]);

    // Overflow: 10 * 0x7FFF.
    do_reset();
    res_q.delete();
    repeat (4) feed(16'h7FFF);
    chk_int("ovf_count", res_q.size(), 4);
`ifdef FIR_MAC_SATURATE_EN
    chk16("ovf_val", (res_q.size() == 4) ? res_q[3] : 16'hDEAD, 16'h7FFF);
    chk_bit("ovf_sat", sat_flag, 1'b1);
`else
    chk16("ovf_val", (res_q.size() == 4) ? res_q[3] : 16'hDEAD, 16'hFFF6);
`endif

    // Coefficient config, busy write ignored, out-of-range write ignored, write+accept together.
    do_reset();
    wcoef(4'd0, 16'h0001); wcoef(4'd1, 16'hFFFF); wcoef(4'd2, 16'h0000); wcoef(4'd3, 16'h0000);
    wcoef(4'd9, 16'h1234);
    res_q.delete();
    cyc(1'b1, 1'b1, 1'b1, 16'd5, 1'b0, 4'h0, 16'h0000);
    cyc(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 4'd0, 16'h0009);
    cyc(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 4'd1, 16'h0009);
    while (ready !== 1'b1 && res_q.size() < 1) idle();
    feed(16'd2);
    cyc(1'b1, 1'b1, 1'b1, 16'd7, 1'b1, 4'd0, 16'h0003);
    while (ready !== 1'b1) idle();
    chk_int("cfg_count", res_q.size(), 3);
    chk16("cfg_r0", (res_q.size() > 0) ? res_q[0] : 16'hDEAD, 16'd5);
    chk16("cfg_r1", (res_q.size() > 1) ? res_q[1] : 16'hDEAD, 16'hFFFD);
    chk16("cfg_r2", (res_q.size() > 2) ? res_q[2] : 16'hDEAD, 16'd19);

    // Backpressure: rIn1 held high with a new sample every cycle.
    res_q.delete();
    for (int i = 0; i < 30; i++) cyc(1'b1, 1'b1, 1'b1, 16'($urandom), 1'b0, 4'h0, 16'h0000);
    chk_int("bp_count", res_q.size(), 5);

    // Stall of 3 cycles during MAC, then a stall across the r_out pulse.
    while (ready !== 1'b1) idle();
    do_reset();
    res_q.delete();
    cyc(1'b1, 1'b1, 1'b1, 16'd1, 1'b0, 4'h0, 16'h0000);
    idle(); idle();
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    lat = 5;
    while (r_out !== 1'b1 && lat < 30) begin idle(); lat++; end
    chk_int("stall_latency", lat, 8);
    chk16("stall_val", dataOut1, 16'd4);
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    chk_bit("stall_pulse_hold", r_out, 1'b1);
    idle();
    chk_bit("pulse_clear", r_out, 1'b0);

    // Reset mid-run with enable low restores coefficients and aborts the run.
    wcoef(4'd0, 16'h0009);
    cyc(1'b1, 1'b1, 1'b1, 16'd1, 1'b0, 4'h0, 16'h0000);
    idle(); idle();
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    chk_bit("midrst_ready", ready, 1'b1);
    chk_bit("midrst_rout", r_out, 1'b0);
    res_q.delete();
    feed(16'd1);
    chk16("midrst_imp", (res_q.size() > 0) ? res_q[0] : 16'hDEAD, 16'd4);

    // Random traffic: enable gaps, config writes to any address, occasional resets.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)),
          16'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
